gate_deadtime_drv: RTL and testbench

//  Gate-side receiver for the PLL's pllout/gate_enbl pair: turns the single-ended
//  PLL phase and interrupter gate into complementary half-bridge gate commands
//  (gate_hi/gate_lo) with guaranteed dead time, minimum-pulse glitch suppression,
//  a stuck-phase watchdog and a latched overcurrent fault. Sits between the PLL

---
 rtl/gate_deadtime_drv.sv | 170 +++++++++++++++++
 tb/tb_gate_deadtime_drv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_deadtime_drv.sv
`default_nettype none
// ============================================================================
//  Module   : gate_deadtime_drv
//  Purpose  : Complementary half-bridge gate commands from PLL phase and
//             interrupter enable, with dead time, glitch filter and fault latch.
//  Revision : 1.0
// ============================================================================
module gate_deadtime_drv #(
    parameter int DEAD_CYCLES   = 8,
    parameter int MIN_ON_CYCLES = 4,
    parameter int MAX_ON_CYCLES = 2500,
    parameter int CNT_W         = 12
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       pllout,
    input  logic       gate_enbl,
    input  logic       ocd_u,
    input  logic       fault_clr,
    output logic       gate_hi,
    output logic       gate_lo,
    output logic       fault,
    output logic [7:0] fault_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAD_HI = 3'd1,
        ST_HI      = 3'd2,
        ST_DEAD_LO = 3'd3,
        ST_LO      = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_dead_load = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] c_min_on    = CNT_W'(MIN_ON_CYCLES);
    localparam logic [CNT_W-1:0] c_max_on    = CNT_W'(MAX_ON_CYCLES);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic             r_ocd_meta;
    logic             r_ocd_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_dead_cnt;
    logic [CNT_W-1:0] r_on_cnt;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_dead_nxt;
    logic [CNT_W-1:0] w_on_nxt;
    logic             w_fault_entry;

    always_comb begin
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;
        w_on_nxt    = r_on_cnt;

        if (r_ocd_s) begin
            w_state_nxt = ST_FAULT;
            w_dead_nxt  = '0;
            w_on_nxt    = '0;
        end else if (!gate_enbl && (r_state != ST_FAULT)) begin
            w_state_nxt = ST_IDLE;
            w_dead_nxt  = c_dead_load;
            w_on_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // gate_enbl is known high here; the enable-low case is handled above
                    if (r_dead_cnt != '0) begin
                        w_dead_nxt = r_dead_cnt - c_one;
                    end else begin
                        w_state_nxt = pllout ? ST_DEAD_HI : ST_DEAD_LO;
                        w_dead_nxt  = c_dead_load;
                    end
                end
                ST_DEAD_HI: begin
                    if (!pllout) begin
                        w_state_nxt = ST_DEAD_LO;
                        w_dead_nxt  = c_dead_load;
                    end else if (r_dead_cnt <= c_one) begin
                        w_state_nxt = ST_HI;
                        w_dead_nxt  = '0;
                        w_on_nxt    = c_one;
                    end else begin
                        w_dead_nxt = r_dead_cnt - c_one;
                    end
                end
                ST_DEAD_LO: begin
                    if (pllout) begin
                        w_state_nxt = ST_DEAD_HI;
                        w_dead_nxt  = c_dead_load;
                    end else if (r_dead_cnt <= c_one) begin
                        w_state_nxt = ST_LO;
                        w_dead_nxt  = '0;
                        w_on_nxt    = c_one;
                    end else begin
                        w_dead_nxt = r_dead_cnt - c_one;
                    end
                end
                ST_HI: begin
                    if (r_on_cnt >= c_max_on) begin
                        w_state_nxt = ST_FAULT;
                        w_on_nxt    = '0;
                    end else if (!pllout && (r_on_cnt >= c_min_on)) begin
                        w_state_nxt = ST_DEAD_LO;
                        w_dead_nxt  = c_dead_load;
                        w_on_nxt    = '0;
                    end else begin
                        w_on_nxt = r_on_cnt + c_one;
                    end
                end
                ST_LO: begin
                    if (r_on_cnt >= c_max_on) begin
                        w_state_nxt = ST_FAULT;
                        w_on_nxt    = '0;
                    end else if (pllout && (r_on_cnt >= c_min_on)) begin
                        w_state_nxt = ST_DEAD_HI;
                        w_dead_nxt  = c_dead_load;
                        w_on_nxt    = '0;
                    end else begin
                        w_on_nxt = r_on_cnt + c_one;
                    end
                end
                ST_FAULT: begin
                    // ocd_s is already known low at this point
                    if (fault_clr) begin
                        w_state_nxt = ST_IDLE;
                        w_dead_nxt  = c_dead_load;
                        w_on_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dead_nxt  = c_dead_load;
                    w_on_nxt    = '0;
                end
            endcase
        end
    end

    assign w_fault_entry = (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_ocd_meta <= 1'b0;
            r_ocd_s    <= 1'b0;
            r_state    <= ST_IDLE;
            r_dead_cnt <= '0;
            r_on_cnt   <= '0;
            gate_hi    <= 1'b0;
            gate_lo    <= 1'b0;
            fault      <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            r_ocd_meta <= ocd_u;
            r_ocd_s    <= r_ocd_meta;
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_on_cnt   <= w_on_nxt;
            // Outputs are registered copies of the state being entered
            gate_hi    <= (w_state_nxt == ST_HI);
            gate_lo    <= (w_state_nxt == ST_LO);
            fault      <= (w_state_nxt == ST_FAULT);
            if (w_fault_entry && (fault_cnt != 8'hFF)) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_deadtime_drv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_deadtime_drv
//  Purpose  : Directed self-checking bench for gate_deadtime_drv.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gate_deadtime_drv;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic       pllout;
    logic       gate_enbl;
    logic       ocd_u;
    logic       fault_clr;
    logic       gate_hi;
    logic       gate_lo;
    logic       fault;
    logic [7:0] fault_cnt;

    int errors = 0;
    int checks = 0;
    int off_run = 0;

    gate_deadtime_drv #(
        .DEAD_CYCLES  (8),
        .MIN_ON_CYCLES(4),
        .MAX_ON_CYCLES(2500),
        .CNT_W        (12)
    ) dut (
        .clk_50   (clk_50),
        .rst      (rst),
        .pllout   (pllout),
        .gate_enbl(gate_enbl),
        .ocd_u    (ocd_u),
        .fault_clr(fault_clr),
        .gate_hi  (gate_hi),
        .gate_lo  (gate_lo),
        .fault    (fault),
        .fault_cnt(fault_cnt)
    );

    always #10 clk_50 = ~clk_50;

    // Continuous safety watch: no overlap, and at least 8 both-off cycles before any rise
    always @(negedge clk_50) begin
        if (gate_hi === 1'b0 && gate_lo === 1'b0) begin
            off_run = off_run + 1;
        end else if (gate_hi === 1'b1 || gate_lo === 1'b1) begin
            checks = checks + 1;
            if (gate_hi === 1'b1 && gate_lo === 1'b1) begin
                errors = errors + 1;
                $display("FAIL overlap: gate_hi=%b gate_lo=%b required not both 1", gate_hi, gate_lo);
            end
            if (off_run > 0) begin
                checks = checks + 1;
                if (off_run < 8) begin
                    errors = errors + 1;
                    $display("FAIL dead_gap: both-off cycles=%0d required >=8", off_run);
                end
            end
            off_run = 0;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pllout = 1'b0; gate_enbl = 1'b0; ocd_u = 1'b0; fault_clr = 1'b0;
        step(3);
        checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL reset_hi: got %b want 0", gate_hi); end
        checks++; if (gate_lo !== 1'b0) begin errors++; $display("FAIL reset_lo: got %b want 0", gate_lo); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset_fcnt: got %0d want 0", fault_cnt); end
    endtask

    task automatic test_square();
        int n_hi, n_lo, n_off;
        int e_hi, e_lo;
        rst = 1'b0; gate_enbl = 1'b1; pllout = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) pllout = ~pllout;
            n_hi = 0; n_lo = 0; n_off = 0;
            for (int c = 0; c < 200; c++) begin
                step(1);
                if (gate_hi === 1'b1) n_hi++;
                if (gate_lo === 1'b1) n_lo++;
                if (gate_hi === 1'b0 && gate_lo === 1'b0) n_off++;
            end
            e_hi = pllout ? 192 : 0;
            e_lo = pllout ? 0 : 192;
            checks++; if (n_hi != e_hi) begin errors++; $display("FAIL square_hi[%0d]: got %0d want %0d", h, n_hi, e_hi); end
            checks++; if (n_lo != e_lo) begin errors++; $display("FAIL square_lo[%0d]: got %0d want %0d", h, n_lo, e_lo); end
            checks++; if (n_off != 8) begin errors++; $display("FAIL square_off[%0d]: got %0d want 8", h, n_off); end
        end
    endtask

    task automatic test_glitch();
        int n_lo;
        n_lo = 0;
        pllout = 1'b0;
        step(1);
        checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL glitch_drop: gate_hi=%b want 0", gate_hi); end
        step(1);
        if (gate_lo === 1'b1) n_lo++;
        pllout = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (gate_lo === 1'b1) n_lo++;
        end
        checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL glitch_dead: gate_hi=%b want 0", gate_hi); end
        checks++; if (n_lo != 0) begin errors++; $display("FAIL glitch_lo: gate_lo high cycles=%0d want 0", n_lo); end
        step(1);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL glitch_rehi: gate_hi=%b want 1", gate_hi); end
        pllout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL glitch_early[%0d]: gate_hi=%b want 1", i, gate_hi); end
        end
        pllout = 1'b1;
        step(1);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL glitch_hold: gate_hi=%b want 1", gate_hi); end
    endtask

    task automatic test_enable();
        pllout = 1'b0;
        step(20);
        checks++; if ({gate_hi, gate_lo} !== 2'b01) begin errors++; $display("FAIL en_lo_on: hi/lo=%b want 01", {gate_hi, gate_lo}); end
        gate_enbl = 1'b0;
        step(1);
        checks++; if ({gate_hi, gate_lo} !== 2'b00) begin errors++; $display("FAIL en_drop: hi/lo=%b want 00", {gate_hi, gate_lo}); end
        step(2);
        gate_enbl = 1'b1;
        step(16);
        checks++; if ({gate_hi, gate_lo} !== 2'b00) begin errors++; $display("FAIL en_wait: hi/lo=%b want 00", {gate_hi, gate_lo}); end
        step(1);
        checks++; if ({gate_hi, gate_lo} !== 2'b01) begin errors++; $display("FAIL en_resume: hi/lo=%b want 01", {gate_hi, gate_lo}); end
    endtask

    task automatic test_ocd();
        pllout = 1'b1;
        step(20);
        checks++; if ({gate_hi, gate_lo} !== 2'b10) begin errors++; $display("FAIL ocd_pre: hi/lo=%b want 10", {gate_hi, gate_lo}); end
        ocd_u = 1'b1;
        step(2);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL ocd_sync: gate_hi=%b want 1", gate_hi); end
        step(1);
        checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL ocd_hi: gate_hi=%b want 0", gate_hi); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ocd_fault: fault=%b want 1", fault); end
        checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL ocd_fcnt: got %0d want 1", fault_cnt); end
        fault_clr = 1'b1;
        step(3);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ocd_clr_held: fault=%b want 1", fault); end
        ocd_u = 1'b0;
        step(2);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ocd_clr_lat: fault=%b want 1", fault); end
        step(1);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ocd_clr: fault=%b want 0", fault); end
        fault_clr = 1'b0;
        step(30);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL ocd_restart: gate_hi=%b want 1", gate_hi); end
        checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL ocd_fcnt_hold: got %0d want 1", fault_cnt); end
    endtask

    task automatic test_stuck();
        pllout = 1'b0;
        step(20);
        pllout = 1'b1;
        step(2508);
        checks++; if ({gate_hi, fault} !== 2'b10) begin errors++; $display("FAIL stuck_last: hi/fault=%b want 10", {gate_hi, fault}); end
        step(1);
        checks++; if ({gate_hi, fault} !== 2'b01) begin errors++; $display("FAIL stuck_trip: hi/fault=%b want 01", {gate_hi, fault}); end
        checks++; if (fault_cnt !== 8'd2) begin errors++; $display("FAIL stuck_fcnt: got %0d want 2", fault_cnt); end
        step(491);
        checks++; if ({gate_hi, gate_lo, fault} !== 3'b001) begin errors++; $display("FAIL stuck_hold: hi/lo/fault=%b want 001", {gate_hi, gate_lo, fault}); end
        fault_clr = 1'b1;
        step(1);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stuck_clr: fault=%b want 0", fault); end
        fault_clr = 1'b0;
    endtask

    task automatic test_fault_saturate();
        for (int i = 1; i <= 300; i++) begin
            ocd_u = 1'b1;
            step(3);
            checks++; if (fault !== 1'b1) begin errors++; $display("FAIL sat_fault[%0d]: fault=%b want 1", i, fault); end
            ocd_u = 1'b0; fault_clr = 1'b1;
            step(3);
            fault_clr = 1'b0;
            step(1);
            if (i == 100) begin
                checks++; if (fault_cnt !== 8'd102) begin errors++; $display("FAIL sat_100: got %0d want 102", fault_cnt); end
            end
            if (i == 253) begin
                checks++; if (fault_cnt !== 8'd255) begin errors++; $display("FAIL sat_253: got %0d want 255", fault_cnt); end
            end
        end
        checks++; if (fault_cnt !== 8'd255) begin errors++; $display("FAIL sat_300: got %0d want 255", fault_cnt); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL sat_exit: fault=%b want 0", fault); end
    endtask

    task automatic test_reset_mid();
        pllout = 1'b1;
        step(30);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL mid_pre: gate_hi=%b want 1", gate_hi); end
        fault_clr = 1'b1;
        step(3);
        checks++; if ({gate_hi, fault} !== 2'b10) begin errors++; $display("FAIL clr_idle: hi/fault=%b want 10", {gate_hi, fault}); end
        fault_clr = 1'b0;
        rst = 1'b1;
        step(1);
        checks++; if ({gate_hi, gate_lo, fault} !== 3'b000) begin errors++; $display("FAIL mid_rst: hi/lo/fault=%b want 000", {gate_hi, gate_lo, fault}); end
        checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_fcnt: got %0d want 0", fault_cnt); end
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_square();
        test_glitch();
        test_enable();
        test_ocd();
        test_stuck();
        test_fault_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
